// File: rtl/vx_scoreboard_multi.sv
`default_nettype none
// ============================================================================
// Module   : vx_scoreboard_multi
// Purpose  : Per-issue-slot register scoreboard with pending-write counters.
//            Each of CHANNELS independent slots runs RAW/WAW hazard checks
//            against per-warp, per-register pending counters. It also tracks
//            a per-warp async busy bit (for async/fence stalls), buffers
//            accepted payloads in a 2-entry skid, and keeps stall, timeout
//            and underflow monitors.
// Ports    : clk, reset (sync, active-low)
//            i_in_*    : ibuffer side (valid, wis, rd, rs1..3, wb, async,
//                        fence, data); o_in_ready back to the ibuffer
//            o_out_*   : operand-collector side (valid, data); i_out_ready
//            i_wb_*    : writeback beats (valid, eop, wis, rd)
//            i_adone_* : async completion (valid, wis)
//            o_stall_cnt, o_timeout, o_err_unflow : per-channel monitors
//            Per-channel buses are flattened: channel c at [c*W +: W].
// Revision : 1.0 - initial release
// ============================================================================
module vx_scoreboard_multi #(
  parameter int CHANNELS     = 4,
  parameter int WARPS_PER_CH = 4,
  parameter int NUM_REGS     = 64,
  parameter int MAX_PEND     = 3,
  parameter int WAW_STALL    = 1,
  parameter int IGNORE_R0    = 1,
  parameter int DATAW        = 128,
  parameter int TIMEOUT      = 4096,
  localparam int c_WIS_W     = (WARPS_PER_CH > 1) ? $clog2(WARPS_PER_CH) : 1,
  localparam int c_NR_W      = $clog2(NUM_REGS),
  localparam int c_CTR_W     = $clog2(MAX_PEND + 1),
  localparam int c_RUN_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          i_in_valid,
  output logic [CHANNELS-1:0]          o_in_ready,
  input  logic [CHANNELS*c_WIS_W-1:0]  i_in_wis,
  input  logic [CHANNELS*c_NR_W-1:0]   i_in_rd,
  input  logic [CHANNELS*c_NR_W-1:0]   i_in_rs1,
  input  logic [CHANNELS*c_NR_W-1:0]   i_in_rs2,
  input  logic [CHANNELS*c_NR_W-1:0]   i_in_rs3,
  input  logic [CHANNELS-1:0]          i_in_wb,
  input  logic [CHANNELS-1:0]          i_in_async,
  input  logic [CHANNELS-1:0]          i_in_fence,
  input  logic [CHANNELS*DATAW-1:0]    i_in_data,
  output logic [CHANNELS-1:0]          o_out_valid,
  input  logic [CHANNELS-1:0]          i_out_ready,
  output logic [CHANNELS*DATAW-1:0]    o_out_data,
  input  logic [CHANNELS-1:0]          i_wb_valid,
  input  logic [CHANNELS-1:0]          i_wb_eop,
  input  logic [CHANNELS*c_WIS_W-1:0]  i_wb_wis,
  input  logic [CHANNELS*c_NR_W-1:0]   i_wb_rd,
  input  logic [CHANNELS-1:0]          i_adone_valid,
  input  logic [CHANNELS*c_WIS_W-1:0]  i_adone_wis,
  output logic [CHANNELS*32-1:0]       o_stall_cnt,
  output logic [CHANNELS-1:0]          o_timeout,
  output logic [CHANNELS-1:0]          o_err_unflow
);

  localparam logic [c_CTR_W-1:0] c_PEND_MAX = c_CTR_W'(MAX_PEND);
  localparam logic [c_CTR_W-1:0] c_PEND_ONE = c_CTR_W'(1);
  localparam logic [c_RUN_W-1:0] c_RUN_MAX  = c_RUN_W'(TIMEOUT);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [c_WIS_W-1:0] w_wis, w_wb_wis, w_ad_wis;
    logic [c_NR_W-1:0]  w_rd, w_rs1, w_rs2, w_rs3, w_wb_rd;
    logic [DATAW-1:0]   w_data;
    logic w_trk_rd, w_trk_rs1, w_trk_rs2, w_trk_rs3, w_trk_wb;
    logic w_raw, w_waw, w_asyn, w_ok, w_fire, w_stall, w_pop;
    logic w_inc, w_dec, w_same;

    logic [c_CTR_W-1:0] r_pend [WARPS_PER_CH][NUM_REGS];
    logic [WARPS_PER_CH-1:0] r_busy;
    logic [1:0]         r_cnt;
    logic [DATAW-1:0]   r_d0, r_d1;
    logic [31:0]        r_stall;
    logic [c_RUN_W-1:0] r_run;
    logic               r_err;

    assign w_wis    = i_in_wis[c*c_WIS_W +: c_WIS_W];
    assign w_wb_wis = i_wb_wis[c*c_WIS_W +: c_WIS_W];
    assign w_ad_wis = i_adone_wis[c*c_WIS_W +: c_WIS_W];
    assign w_rd     = i_in_rd[c*c_NR_W +: c_NR_W];
    assign w_rs1    = i_in_rs1[c*c_NR_W +: c_NR_W];
    assign w_rs2    = i_in_rs2[c*c_NR_W +: c_NR_W];
    assign w_rs3    = i_in_rs3[c*c_NR_W +: c_NR_W];
    assign w_wb_rd  = i_wb_rd[c*c_NR_W +: c_NR_W];
    assign w_data   = i_in_data[c*DATAW +: DATAW];

    // Register 0 is invisible to the scoreboard when IGNORE_R0 is set.
    assign w_trk_rd  = (IGNORE_R0 == 0) || (w_rd    != '0);
    assign w_trk_rs1 = (IGNORE_R0 == 0) || (w_rs1   != '0);
    assign w_trk_rs2 = (IGNORE_R0 == 0) || (w_rs2   != '0);
    assign w_trk_rs3 = (IGNORE_R0 == 0) || (w_rs3   != '0);
    assign w_trk_wb  = (IGNORE_R0 == 0) || (w_wb_rd != '0);

    // Hazards use the pre-update counters, so a same-cycle writeback
    // only unblocks a dependent instruction on the following cycle.
    assign w_raw = (w_trk_rs1 && (r_pend[w_wis][w_rs1] != '0)) ||
                   (w_trk_rs2 && (r_pend[w_wis][w_rs2] != '0)) ||
                   (w_trk_rs3 && (r_pend[w_wis][w_rs3] != '0));
    assign w_waw = i_in_wb[c] && w_trk_rd &&
                   ((WAW_STALL != 0) ? (r_pend[w_wis][w_rd] != '0)
                                     : (r_pend[w_wis][w_rd] == c_PEND_MAX));
    assign w_asyn = (i_in_fence[c] || i_in_async[c]) && r_busy[w_wis];
    assign w_ok   = !(w_raw || w_waw || w_asyn);

    // Skid accepts only while it has a free slot; ready is deliberately
    // independent of i_in_valid.
    assign o_in_ready[c] = reset && w_ok && (r_cnt != 2'd2);
    assign w_fire  = i_in_valid[c] && o_in_ready[c];
    assign w_stall = i_in_valid[c] && !o_in_ready[c];
    assign w_pop   = (r_cnt != 2'd0) && i_out_ready[c];

    assign w_inc  = w_fire && i_in_wb[c] && w_trk_rd;
    assign w_dec  = i_wb_valid[c] && i_wb_eop[c] && w_trk_wb;
    assign w_same = (w_wis == w_wb_wis) && (w_rd == w_wb_rd);

    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int w = 0; w < WARPS_PER_CH; w++) begin
          for (int r = 0; r < NUM_REGS; r++) begin
            r_pend[w][r] <= '0;
          end
        end
        r_busy  <= '0;
        r_cnt   <= 2'd0;
        r_d0    <= '0;
        r_d1    <= '0;
        r_stall <= '0;
        r_run   <= '0;
        r_err   <= 1'b0;
      end else begin
        // Matching increment and decrement cancel out.
        if (!(w_inc && w_dec && w_same)) begin
          if (w_inc) begin
            r_pend[w_wis][w_rd] <= r_pend[w_wis][w_rd] + c_PEND_ONE;
          end
          if (w_dec) begin
            if (r_pend[w_wb_wis][w_wb_rd] == '0) begin
              r_err <= 1'b1;
            end else begin
              r_pend[w_wb_wis][w_wb_rd] <= r_pend[w_wb_wis][w_wb_rd] - c_PEND_ONE;
            end
          end
        end

        // Set is applied last so it wins over a same-warp completion.
        if (i_adone_valid[c]) begin
          r_busy[w_ad_wis] <= 1'b0;
        end
        if (w_fire && i_in_async[c]) begin
          r_busy[w_wis] <= 1'b1;
        end

        // Two-entry skid; r_d0 is always the presented head.
        case (r_cnt)
          2'd0: begin
            if (w_fire) begin
              r_d0  <= w_data;
              r_cnt <= 2'd1;
            end
          end
          2'd1: begin
            if (w_fire && w_pop) begin
              r_d0 <= w_data;
            end else if (w_fire) begin
              r_d1  <= w_data;
              r_cnt <= 2'd2;
            end else if (w_pop) begin
              r_cnt <= 2'd0;
            end
          end
          2'd2: begin
            if (w_pop) begin
              r_d0  <= r_d1;
              r_cnt <= 2'd1;
            end
          end
          default: r_cnt <= 2'd0;
        endcase

        if (w_stall && (r_stall != 32'hFFFF_FFFF)) begin
          r_stall <= r_stall + 32'd1;
        end
        if (w_fire) begin
          r_run <= '0;
        end else if (w_stall && (r_run != c_RUN_MAX)) begin
          r_run <= r_run + c_RUN_W'(1);
        end
      end
    end

    assign o_out_valid[c]             = (r_cnt != 2'd0);
    assign o_out_data[c*DATAW +: DATAW] = r_d0;
    assign o_stall_cnt[c*32 +: 32]    = r_stall;
    assign o_timeout[c]               = (r_run >= c_RUN_MAX);
    assign o_err_unflow[c]            = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_scoreboard_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_scoreboard_multi
// Purpose  : Self-checking bench for vx_scoreboard_multi. Random instruction,
//            writeback and async-completion traffic is scored against a
//            behavioural model of pending counts, busy bits and skid
//            occupancy; accepted payloads are queued and a monitor compares
//            them against whatever the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_scoreboard_multi;

  localparam int CH   = 4;
  localparam int WPC  = 4;
  localparam int NREG = 64;
  localparam int MAXP = 3;
  localparam int WAWS = 0;
  localparam int IGN  = 1;
  localparam int DW   = 32;
  localparam int TO   = 32;
  localparam int WW   = 2;
  localparam int RW   = 6;

  logic clk = 1'b0;
  logic reset;
  logic [CH-1:0]    in_valid, in_ready, in_wb, in_async, in_fence;
  logic [CH*WW-1:0] in_wis, wb_wis, adone_wis;
  logic [CH*RW-1:0] in_rd, in_rs1, in_rs2, in_rs3, wb_rd;
  logic [CH*DW-1:0] in_data, out_data;
  logic [CH-1:0]    out_valid, out_ready, wb_valid, wb_eop, adone_valid;
  logic [CH*32-1:0] stall_cnt;
  logic [CH-1:0]    timeout, err_unflow;

  always #5 clk = ~clk;

  vx_scoreboard_multi #(
    .CHANNELS(CH), .WARPS_PER_CH(WPC), .NUM_REGS(NREG), .MAX_PEND(MAXP),
    .WAW_STALL(WAWS), .IGNORE_R0(IGN), .DATAW(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_wis(in_wis),
    .i_in_rd(in_rd), .i_in_rs1(in_rs1), .i_in_rs2(in_rs2), .i_in_rs3(in_rs3),
    .i_in_wb(in_wb), .i_in_async(in_async), .i_in_fence(in_fence),
    .i_in_data(in_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .i_wb_valid(wb_valid), .i_wb_eop(wb_eop),
    .i_wb_wis(wb_wis), .i_wb_rd(wb_rd), .i_adone_valid(adone_valid),
    .i_adone_wis(adone_wis), .o_stall_cnt(stall_cnt), .o_timeout(timeout),
    .o_err_unflow(err_unflow)
  );

  int errors = 0;
  int checks = 0;

  // Stimulus for the current cycle, one entry per channel.
  bit s_valid[CH], s_wb[CH], s_async[CH], s_fence[CH], s_oready[CH];
  bit s_wbv[CH], s_eop[CH], s_adv[CH];
  int s_wis[CH], s_rd[CH], s_rs1[CH], s_rs2[CH], s_rs3[CH];
  int s_wbw[CH], s_wbr[CH], s_adw[CH];
  logic [DW-1:0] s_data[CH];

  // Reference model state.
  int      m_pend[CH][WPC][NREG];
  bit      m_busy[CH][WPC];
  int      m_occ[CH];
  longint  m_stall[CH];
  int      m_run[CH];
  bit      m_err[CH];
  logic [DW-1:0] q[CH][$];

  task automatic chk(string nm, int c, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ch%0d @%0t: got %0h expected %0h", nm, c, $time, act, exp);
    end
  endtask

  function automatic bit trk(int r);
    return (IGN == 0) || (r != 0);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      for (int w = 0; w < WPC; w++) begin
        m_busy[c][w] = 1'b0;
        for (int r = 0; r < NREG; r++) m_pend[c][w][r] = 0;
      end
      m_occ[c] = 0; m_stall[c] = 0; m_run[c] = 0; m_err[c] = 1'b0;
      q[c].delete();
    end
  endtask

  task automatic apply();
    for (int c = 0; c < CH; c++) begin
      in_valid[c] = s_valid[c]; in_wb[c] = s_wb[c];
      in_async[c] = s_async[c]; in_fence[c] = s_fence[c];
      out_ready[c] = s_oready[c];
      wb_valid[c] = s_wbv[c]; wb_eop[c] = s_eop[c]; adone_valid[c] = s_adv[c];
      in_wis[c*WW +: WW]    = WW'(s_wis[c]);
      wb_wis[c*WW +: WW]    = WW'(s_wbw[c]);
      adone_wis[c*WW +: WW] = WW'(s_adw[c]);
      in_rd[c*RW +: RW]  = RW'(s_rd[c]);
      in_rs1[c*RW +: RW] = RW'(s_rs1[c]);
      in_rs2[c*RW +: RW] = RW'(s_rs2[c]);
      in_rs3[c*RW +: RW] = RW'(s_rs3[c]);
      wb_rd[c*RW +: RW]  = RW'(s_wbr[c]);
      in_data[c*DW +: DW] = s_data[c];
    end
  endtask

  task automatic gen_idle(bit oready);
    for (int c = 0; c < CH; c++) begin
      s_valid[c] = 0; s_wb[c] = 0; s_async[c] = 0; s_fence[c] = 0;
      s_oready[c] = oready; s_wbv[c] = 0; s_eop[c] = 0; s_adv[c] = 0;
      s_wis[c] = 0; s_rd[c] = 0; s_rs1[c] = 0; s_rs2[c] = 0; s_rs3[c] = 0;
      s_wbw[c] = 0; s_wbr[c] = 0; s_adw[c] = 0; s_data[c] = '0;
    end
  endtask

  // Small register range so hazards are frequent.
  task automatic gen_random();
    for (int c = 0; c < CH; c++) begin
      s_valid[c] = ($urandom % 4) != 0;
      s_wis[c]   = $urandom % WPC;
      s_rd[c]    = $urandom % 4;
      s_rs1[c]   = $urandom % 4;
      s_rs2[c]   = $urandom % 4;
      s_rs3[c]   = $urandom % 4;
      s_wb[c]    = ($urandom % 2) != 0;
      s_async[c] = ($urandom % 8) == 0;
      s_fence[c] = ($urandom % 8) == 0;
      s_data[c]  = $urandom;
      s_oready[c] = ($urandom % 4) != 0;
      if (($urandom % 4) == 0) begin
        s_wbw[c] = s_wis[c]; s_wbr[c] = s_rd[c];
      end else begin
        s_wbw[c] = $urandom % WPC; s_wbr[c] = $urandom % 4;
      end
      s_wbv[c] = (m_pend[c][s_wbw[c]][s_wbr[c]] > 0) ? (($urandom % 2) != 0)
                                                      : (($urandom % 64) == 0);
      s_eop[c] = ($urandom % 4) != 0;
      s_adw[c] = $urandom % WPC;
      s_adv[c] = m_busy[c][s_adw[c]] ? (($urandom % 4) == 0) : (($urandom % 16) == 0);
    end
  endtask

  // Hazard-free traffic against a blocked output to fill skids and time out.
  task automatic gen_backpressure();
    gen_idle(1'b0);
    for (int c = 0; c < CH; c++) begin
      s_valid[c] = 1'b1;
      s_data[c]  = $urandom;
    end
  endtask

  // Called at the negedge: registered outputs reflect the model state
  // before this cycle's inputs are applied.
  task automatic model_step();
    bit raw, waw, asyn, rdy, fire, pop, inc, dec, same;
    for (int c = 0; c < CH; c++) begin
      chk("out_valid", c, longint'(out_valid[c]), longint'(m_occ[c] != 0));
      chk("stall_cnt", c, longint'(stall_cnt[c*32 +: 32]), m_stall[c]);
      chk("timeout", c, longint'(timeout[c]), longint'(m_run[c] >= TO));
      chk("err_unflow", c, longint'(err_unflow[c]), longint'(m_err[c]));
      if (!reset) begin
        chk("in_ready_rst", c, longint'(in_ready[c]), 0);
        continue;
      end
      raw = (trk(s_rs1[c]) && m_pend[c][s_wis[c]][s_rs1[c]] != 0) ||
            (trk(s_rs2[c]) && m_pend[c][s_wis[c]][s_rs2[c]] != 0) ||
            (trk(s_rs3[c]) && m_pend[c][s_wis[c]][s_rs3[c]] != 0);
      waw = s_wb[c] && trk(s_rd[c]) &&
            ((WAWS != 0) ? (m_pend[c][s_wis[c]][s_rd[c]] != 0)
                         : (m_pend[c][s_wis[c]][s_rd[c]] == MAXP));
      asyn = (s_fence[c] || s_async[c]) && m_busy[c][s_wis[c]];
      rdy  = !(raw || waw || asyn) && (m_occ[c] < 2);
      chk("in_ready", c, longint'(in_ready[c]), longint'(rdy));
      fire = s_valid[c] && rdy;
      pop  = (m_occ[c] != 0) && s_oready[c];
      if (fire) q[c].push_back(s_data[c]);
      m_occ[c] = m_occ[c] + int'(fire) - int'(pop);
      if (s_valid[c] && !rdy && m_stall[c] < 64'hFFFF_FFFF) m_stall[c]++;
      if (fire) m_run[c] = 0;
      else if (s_valid[c] && !rdy && m_run[c] < TO) m_run[c]++;
      inc  = fire && s_wb[c] && trk(s_rd[c]);
      dec  = s_wbv[c] && s_eop[c] && trk(s_wbr[c]);
      same = (s_wis[c] == s_wbw[c]) && (s_rd[c] == s_wbr[c]);
      if (!(inc && dec && same)) begin
        if (inc) m_pend[c][s_wis[c]][s_rd[c]]++;
        if (dec) begin
          if (m_pend[c][s_wbw[c]][s_wbr[c]] == 0) m_err[c] = 1'b1;
          else m_pend[c][s_wbw[c]][s_wbr[c]]--;
        end
      end
      if (s_adv[c]) m_busy[c][s_adw[c]] = 1'b0;
      if (fire && s_async[c]) m_busy[c][s_wis[c]] = 1'b1;
    end
  endtask

  // Monitor: the presented head must equal the oldest accepted payload,
  // and is retired on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (reset && out_valid[c]) begin
          if (q[c].size() == 0) begin
            chk("out_unexpected", c, 1, 0);
          end else begin
            chk("out_data", c, longint'(out_data[c*DW +: DW]), longint'(q[c][0]));
            if (out_ready[c]) void'(q[c].pop_front());
          end
        end
      end
    end
  end

  task automatic cycle(int mode, bit rst_n);
    @(posedge clk);
    #1;
    reset = rst_n;
    case (mode)
      0: gen_idle(1'b0);
      1: gen_random();
      2: gen_backpressure();
      default: gen_idle(1'b1);
    endcase
    apply();
    @(negedge clk);
    model_step();
    if (!rst_n) model_clear();
  endtask

  initial begin
    reset = 1'b0;
    gen_idle(1'b0);
    apply();
    model_clear();
    repeat (3) cycle(0, 1'b0);
    repeat (400) cycle(1, 1'b1);
    repeat (45) cycle(2, 1'b1);
    cycle(0, 1'b0);
    repeat (400) cycle(1, 1'b1);
    repeat (45) cycle(2, 1'b1);
    repeat (6) cycle(3, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
